// File: rtl/esm_slot_scheduler_if.sv
// Slot scheduler port bundle: allocation, mark, issue handshake and status.
// master drives requests; slave is the scheduler.
interface esm_slot_scheduler_if #(
  parameter int BS = 16
);
  localparam int BSW = $clog2(BS);

  logic           flush;
  logic           alloc_req;
  logic           alloc_gnt;
  logic [BSW-1:0] alloc_idx;
  logic           mark_valid;
  logic [BSW-1:0] mark_idx;
  logic           issue_valid;
  logic           issue_ready;
  logic [BSW-1:0] issue_idx;
  logic [BSW:0]   free_count;
  logic [BSW:0]   ready_count;
  logic           mark_err;

  modport master (
    output flush, alloc_req, mark_valid, mark_idx, issue_ready,
    input  alloc_gnt, alloc_idx, issue_valid, issue_idx,
    input  free_count, ready_count, mark_err
  );

  modport slave (
    input  flush, alloc_req, mark_valid, mark_idx, issue_ready,
    output alloc_gnt, alloc_idx, issue_valid, issue_idx,
    output free_count, ready_count, mark_err
  );
endinterface

// File: rtl/esm_slot_scheduler.sv
// Shuffle-buffer slot scheduler: allocates free slots, issues ready slots in LFSR order.
// Define ESM_SCHED_LINEAR_EN to always issue the lowest-indexed ready slot instead.
module esm_slot_scheduler #(
  parameter int          BS        = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  esm_slot_scheduler_if.slave sif
);
  localparam int BSW = $clog2(BS);

  typedef enum logic [1:0] {IDLE, PICK, ISSUE} state_e;

  state_e         state_q, state_d;
  logic [BS-1:0]  occ_q, occ_d;
  logic [BS-1:0]  rdy_q, rdy_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic [BSW-1:0] idx_q, idx_d;

  logic [BSW:0]   free_cnt, rdy_cnt;
  logic [BSW-1:0] free_idx, sel_idx;
  logic [15:0]    k, cnt;
  logic           found;

  function automatic logic [BSW:0] popcnt(input logic [BS-1:0] v);
    logic [BSW:0] s;
    s = '0;
    for (int i = 0; i < BS; i++) s = s + {{BSW{1'b0}}, v[i]};
    return s;
  endfunction

  assign free_cnt = (BSW+1)'(BS) - popcnt(occ_q);
  assign rdy_cnt  = popcnt(rdy_q);

  always_comb begin
    free_idx = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (!occ_q[i]) free_idx = BSW'(i);
    end
  end

  // k-th set bit of rdy, counting from bit 0
  always_comb begin
`ifdef ESM_SCHED_LINEAR_EN
    k = 16'd0;
`else
    k = (rdy_cnt == '0) ? 16'd0 : lfsr_q % 16'(rdy_cnt);
`endif
    sel_idx = '0;
    cnt     = 16'd0;
    found   = 1'b0;
    for (int i = 0; i < BS; i++) begin
      if (rdy_q[i] && !found) begin
        if (cnt == k) begin
          sel_idx = BSW'(i);
          found   = 1'b1;
        end
        cnt = cnt + 16'd1;
      end
    end
  end

  assign sif.alloc_gnt   = sif.alloc_req && (free_cnt != '0);
  assign sif.alloc_idx   = free_idx;
  assign sif.issue_valid = valid_q;
  assign sif.issue_idx   = idx_q;
  assign sif.free_count  = free_cnt;
  assign sif.ready_count = rdy_cnt;
  assign sif.mark_err    = err_q;

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    rdy_d   = rdy_q;
    valid_d = valid_q;
    err_d   = err_q;
    idx_d   = idx_q;
    lfsr_d  = {lfsr_q[14:0],
               lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (sif.flush) begin
      occ_d   = '0;
      rdy_d   = '0;
      err_d   = 1'b0;
      valid_d = 1'b0;
      state_d = IDLE;
    end else begin
      if (sif.alloc_gnt) occ_d[free_idx] = 1'b1;
      // marks are judged on pre-edge occupancy
      if (sif.mark_valid) begin
        if (occ_q[sif.mark_idx] && !rdy_q[sif.mark_idx])
          rdy_d[sif.mark_idx] = 1'b1;
        else
          err_d = 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (rdy_cnt != '0) state_d = PICK;
        end
        PICK: begin
          if (rdy_cnt != '0) begin
            idx_d   = sel_idx;
            valid_d = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
        ISSUE: begin
          if (sif.issue_ready) begin
            occ_d[idx_q] = 1'b0;
            rdy_d[idx_q] = 1'b0;
            valid_d      = 1'b0;
            state_d      = (popcnt(rdy_d) != '0) ? PICK : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      occ_q   <= '0;
      rdy_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      rdy_q   <= rdy_d;
      lfsr_q  <= lfsr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end
endmodule
